motor_pwm_arranque: RTL
=======================

Name: motor_pwm_arranque

Overview:
- Downstream stage of the motor sequencing controller.
- Consumes the MOTOR1/MOTOR2 run-request levels and drives two power-stage PWM outputs, each with a soft-start duty ramp.
- Allows only one channel to ramp at a time, which limits inrush current; the other channel waits.
- Reports per-channel "at full speed" status back to the system.

Parameters:
PWM_W, 4, PWM counter width; PWM period = 2^PWM_W cycles
RAMP_DIV, 2, PWM periods per +1 duty step during ramp (>=1)

Ports:
CLK  input  1  system clock, rising edge
REINICIO  input  1  synchronous reset, active-low
MOTOR1  input  1  run request channel 1 (level, from sequencing controller)
MOTOR2  input  1  run request channel 2 (level)
PWM1  output  1  gate drive channel 1, registered
PWM2  output  1  gate drive channel 2, registered
MARCHA1  output  1  channel 1 at full duty (state RUN), registered
MARCHA2  output  1  channel 2 at full duty, registered

Behaviour:
- Clock and reset: one clock CLK; reset REINICIO is synchronous and active-low, sampled only on the CLK rising edge.
- Reset values: cnt=0, both channels OFF, duty=0, divider=0, PWM1=PWM2=MARCHA1=MARCHA2=0.
- Shared PWM counter cnt:
  - PWM_W bits, free-running 0..2^PWM_W-1, wraps to 0.
  - "Period end" = cycle with cnt==2^PWM_W-1.
- Per-channel state: duty register, PWM_W+1 bits, range 0..2^PWM_W; RAMP_DIV divider.
- Per-channel FSM states: OFF, WAIT, RAMP, RUN.
  - OFF: duty=0. MOTORx=1 -> RAMP if the other channel is not in RAMP and not entering RAMP this cycle; otherwise -> WAIT.
  - WAIT: duty=0. Other channel not in RAMP -> RAMP; divider cleared.
  - RAMP: at each period end, divider increments. When divider==RAMP_DIV-1, divider clears and duty increments by 1. When duty reaches 2^PWM_W -> RUN in the same cycle; duty saturates and never exceeds 2^PWM_W.
  - RUN: duty held at 2^PWM_W.
  - Any state with MOTORx=0 -> OFF next cycle; duty and divider cleared. This has priority over all other transitions.
- Simultaneous start: both channels request from OFF in the same cycle -> channel 1 -> RAMP, channel 2 -> WAIT.
- Arbitration: the arbiter never allows both channels in RAMP in the same cycle.
- A channel in WAIT enters RAMP the cycle after the other channel leaves RAMP, whether to RUN or OFF.
- PWMx (next cycle) = (state!=OFF && state!=WAIT) && (cnt < duty), using the current-cycle cnt and duty.
  - duty=2^PWM_W gives constant 1.
  - duty=0 gives constant 0.
- MARCHAx (next cycle) = (next state == RUN).
- Request drop: PWMx and MARCHAx are 0 from the cycle after the FSM enters OFF, i.e. within 2 cycles of MOTORx falling.
- Re-request while a channel is ramping down to OFF: no memory; the ramp restarts from duty 0.
- Ramp duration: from entering RAMP to RUN is between (2^PWM_W*RAMP_DIV-1) and 2^PWM_W*RAMP_DIV full PWM periods, plus at most one partial period.
  - Defaults: 31–33 periods, i.e. about 496–528 cycles.
- Mid-operation reset: REINICIO=0 in any state -> all reset values next edge, regardless of MOTORx.
- MOTORx are synchronous to CLK; no synchronizers inside the block.

Test Plan:
- Reset: REINICIO=0 for 3 cycles with MOTOR1=MOTOR2=1 -> PWM1/2 and MARCHA1/2 stay 0; cnt=0 on release.
- Single-channel soft start:
  - Stimulus: MOTOR1 rises, MOTOR2=0, defaults.
  - PWM1 high-time per 16-cycle period is non-decreasing, stepping by 1 every 2 periods.
  - MARCHA1=1 within 496–528 cycles, then PWM1 constant 1.
  - PWM2=0 throughout.
- Simultaneous request:
  - Stimulus: MOTOR1 and MOTOR2 rise in the same cycle.
  - Channel 2 is in WAIT with PWM2=0 until MARCHA1 rises.
  - Channel 2 ramp starts the cycle after; MARCHA2 rises about 500 cycles after MARCHA1.
  - PWM1 and PWM2 are never both ramping at once; checked with an assertion on the internal states.
- Drop during ramp:
  - Stimulus: MOTOR1 falls with channel 1 at duty=7 while channel 2 waits.
  - PWM1 is 0 within 2 cycles and channel 2 enters RAMP.
  - MOTOR1 re-asserted -> channel 1 goes to WAIT and restarts from duty 0 once channel 2 reaches RUN.
- Reset mid-ramp: REINICIO pulsed low 1 cycle with channel 1 in RAMP and channel 2 in RUN -> all outputs 0 next cycle. With requests held high, channel 1 ramps first again from duty 0.
- Parameter sweep: PWM_W=3, RAMP_DIV=1 -> period 8. MARCHA1 within 7–9 periods of MOTOR1 rising; PWM1 high-time increases by 1 each period.

Source files
------------

// File: rtl/motor_pwm_arranque.sv
// Two-channel soft-start PWM driver; a shared counter sets the PWM period and only one channel ramps at a time.
// All outputs registered (one cycle after state/cnt); channel 1 wins simultaneous starts and the loser parks in WAIT.
module motor_pwm_arranque #(
   parameter int PWM_W    = 4,
   parameter int RAMP_DIV = 2
) (
   input  logic CLK,
   input  logic REINICIO,
   input  logic MOTOR1,
   input  logic MOTOR2,
   output logic PWM1,
   output logic PWM2,
   output logic MARCHA1,
   output logic MARCHA2
);
   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PWM_W:0]   FULL     = {1'b1, {PWM_W{1'b0}}};
   localparam logic [PWM_W:0]   DUTY_ONE = {{PWM_W{1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(1);

   typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RAMP, ST_RUN} state_t;

   logic [PWM_W-1:0] cnt_q, cnt_d;
   state_t           st1_q, st1_d, st2_q, st2_d;
   logic [PWM_W:0]   duty1_q, duty1_d, duty2_q, duty2_d;
   logic [DIV_W-1:0] div1_q, div1_d, div2_q, div2_d;
   logic             pwm1_q, pwm1_d, pwm2_q, pwm2_d;
   logic             mar1_q, mar1_d, mar2_q, mar2_d;
   logic             period_end, ramp1, ramp2, wake2, enter1;

   assign cnt_d      = cnt_q + CNT_ONE;
   assign period_end = &cnt_q;
   assign ramp1      = (st1_q == ST_RAMP);
   assign ramp2      = (st2_q == ST_RAMP);
   // Channel 2 leaving WAIT this cycle blocks a fresh channel 1 start, so the arbiter never grants twice.
   assign wake2      = MOTOR2 && (st2_q == ST_WAIT) && !ramp1;
   assign enter1     = (st1_d == ST_RAMP) && !ramp1;

   always_comb begin
      st1_d   = st1_q;
      duty1_d = duty1_q;
      div1_d  = div1_q;
      if (!MOTOR1) begin
         st1_d   = ST_OFF;
         duty1_d = '0;
         div1_d  = '0;
      end else begin
         case (st1_q)
            ST_OFF:  st1_d = (ramp2 || wake2) ? ST_WAIT : ST_RAMP;
            ST_WAIT: begin
               div1_d = '0;
               if (!ramp2) st1_d = ST_RAMP;
            end
            ST_RAMP: begin
               if (period_end) begin
                  if (div1_q == DIV_LAST) begin
                     div1_d  = '0;
                     duty1_d = duty1_q + DUTY_ONE;
                     if (duty1_q == FULL - DUTY_ONE) st1_d = ST_RUN;
                  end else begin
                     div1_d = div1_q + DIV_ONE;
                  end
               end
            end
            default: duty1_d = FULL;
         endcase
      end
   end

   always_comb begin
      st2_d   = st2_q;
      duty2_d = duty2_q;
      div2_d  = div2_q;
      if (!MOTOR2) begin
         st2_d   = ST_OFF;
         duty2_d = '0;
         div2_d  = '0;
      end else begin
         case (st2_q)
            ST_OFF:  st2_d = (ramp1 || enter1) ? ST_WAIT : ST_RAMP;
            ST_WAIT: begin
               div2_d = '0;
               if (!ramp1) st2_d = ST_RAMP;
            end
            ST_RAMP: begin
               if (period_end) begin
                  if (div2_q == DIV_LAST) begin
                     div2_d  = '0;
                     duty2_d = duty2_q + DUTY_ONE;
                     if (duty2_q == FULL - DUTY_ONE) st2_d = ST_RUN;
                  end else begin
                     div2_d = div2_q + DIV_ONE;
                  end
               end
            end
            default: duty2_d = FULL;
         endcase
      end
   end

   assign pwm1_d = ((st1_q == ST_RAMP) || (st1_q == ST_RUN)) && ({1'b0, cnt_q} < duty1_q);
   assign pwm2_d = ((st2_q == ST_RAMP) || (st2_q == ST_RUN)) && ({1'b0, cnt_q} < duty2_q);
   assign mar1_d = (st1_d == ST_RUN);
   assign mar2_d = (st2_d == ST_RUN);

   always_ff @(posedge CLK) begin
      if (!REINICIO) begin
         cnt_q   <= '0;
         st1_q   <= ST_OFF;
         st2_q   <= ST_OFF;
         duty1_q <= '0;
         duty2_q <= '0;
         div1_q  <= '0;
         div2_q  <= '0;
         pwm1_q  <= 1'b0;
         pwm2_q  <= 1'b0;
         mar1_q  <= 1'b0;
         mar2_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         st1_q   <= st1_d;
         st2_q   <= st2_d;
         duty1_q <= duty1_d;
         duty2_q <= duty2_d;
         div1_q  <= div1_d;
         div2_q  <= div2_d;
         pwm1_q  <= pwm1_d;
         pwm2_q  <= pwm2_d;
         mar1_q  <= mar1_d;
         mar2_q  <= mar2_d;
      end
   end

   assign PWM1    = pwm1_q;
   assign PWM2    = pwm2_q;
   assign MARCHA1 = mar1_q;
   assign MARCHA2 = mar2_q;
endmodule
